sram_like_responder: RTL and testbench

- Memory-side responder for the core's SRAM-like request/response interface (req/addr_ok/data_ok).
- Serves as the slave endpoint for either the inst or data port in block-level and top-level simulation.
- Accepts address handshakes, performs word-wide reads and byte-strobed writes on an internal word array, and returns one in-order data_ok response per accepted request after a configurable latency.
- Two mask inputs let the bench inject address-side and response-side stalls.

---
 rtl/sram_like_responder.sv | 105 ++++++++++
 tb/tb_sram_like_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// SRAM-like slave endpoint: word array with byte-strobed writes and an in-order
// response queue that returns one data_ok per accepted request after LAT cycles.
module sram_like_responder #(
  parameter int unsigned AW     = 10,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned LAT    = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req,
  input  logic                      wr,
  input  logic [1:0]                size,
  input  logic [3:0]                wstrb,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic                      addr_ok,
  output logic                      data_ok,
  output logic [31:0]               rdata,
  input  logic                      addr_stall,
  input  logic                      data_stall,
  output logic [$clog2(QDEPTH):0]   outstanding
);

  localparam int unsigned PW = $clog2(QDEPTH);

  typedef logic [3:0] age_t;

  logic [31:0]   mem [2**AW];
  logic [31:0]   qdata_q [QDEPTH];
  age_t          qage_q  [QDEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          data_ok_q;
  logic [31:0]   rdata_q;

  logic          full;
  logic          push;
  logic          pop;
  logic [AW-1:0] idx;
  logic          unused;

  assign idx     = addr[AW+1:2];
  assign full    = (cnt_q == (PW+1)'(QDEPTH));
  assign addr_ok = resetn & ~full & ~addr_stall;
  assign push    = req & addr_ok;

  // Ages start at 0 on the handshake edge, so the head is popped once it has
  // seen LAT-1 more edges; that lands data_ok exactly LAT edges after handshake.
  assign pop = (cnt_q != '0) && (qage_q[rptr_q] >= age_t'(LAT - 1)) && !data_stall;

  assign unused = ^{size, addr[31:AW+2], addr[1:0]};

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) qage_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (qage_q[i] < age_t'(LAT)) qage_q[i] <= qage_q[i] + 1'b1;
      end
      if (push) qage_q[wptr_q] <= '0;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      data_ok_q <= pop;
      if (pop) rdata_q <= qdata_q[rptr_q];
    end
  end

  // Queue payload and the array itself carry no reset; push already implies resetn.
  always_ff @(posedge clk) begin
    if (push) qdata_q[wptr_q] <= wr ? '0 : mem[idx];
  end

  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign data_ok     = data_ok_q;
  assign rdata       = rdata_q;
  assign outstanding = cnt_q;

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: reference word model feeds an in-order scoreboard
// of expected responses; scenario tasks add cycle-exact handshake/response checks.
module tb_sram_like_responder;

  localparam int unsigned AW     = 10;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned LAT    = 2;
  localparam int unsigned OW     = $clog2(QDEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [1:0]    size = 2'd2;
  logic [3:0]    wstrb = '0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic          addr_ok;
  logic          data_ok;
  logic [31:0]   rdata;
  logic          addr_stall = 1'b0;
  logic          data_stall = 1'b0;
  logic [OW-1:0] outstanding;

  always #5 clk = ~clk;

  sram_like_responder #(.AW(AW), .QDEPTH(QDEPTH), .LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .addr_stall(addr_stall), .data_stall(data_stall), .outstanding(outstanding)
  );

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  int n_resp = 0;

  typedef struct {
    logic [31:0] data;
    int          e;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] model [int];

  // Handshakes are judged on pre-edge values; the model memory applies them in order.
  always @(posedge clk) begin
    edge_n++;
    if (resetn && req && addr_ok) begin
      int          mi;
      logic [31:0] w;
      sb_t         ent;
      mi = int'(addr[AW+1:2]);
      w  = model.exists(mi) ? model[mi] : 32'h0;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
        model[mi] = w;
        ent.data  = 32'h0;
      end else begin
        ent.data = w;
      end
      ent.e = edge_n;
      sb.push_back(ent);
    end
  end

  always @(negedge resetn) sb.delete();

  always @(negedge clk) begin
    if (resetn) begin
      if (data_ok) begin
        n_resp++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: data_ok=1 with rdata=%h, required no response", rdata);
        end else begin
          sb_t ent;
          ent = sb.pop_front();
          if (rdata !== ent.data) begin
            n_err++;
            $display("FAIL sb_rdata: got %h, required %h", rdata, ent.data);
          end
          n_cmp++;
          if ((edge_n - ent.e) < int'(LAT)) begin
            n_err++;
            $display("FAIL sb_latency: got %0d edges, required >= %0d", edge_n - ent.e, LAT);
          end
        end
      end
      n_cmp++;
      if (outstanding !== OW'(sb.size())) begin
        n_err++;
        $display("FAIL sb_occupancy: outstanding=%0d, required %0d", outstanding, sb.size());
      end
    end
  end

  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input bit rand_stall);
    bit done;
    done  = 1'b0;
    req   = 1'b1;
    wr    = w;
    wstrb = s;
    addr  = a;
    wdata = d;
    for (int k = 0; k < 200 && !done; k++) begin
      done = addr_ok;
      @(negedge clk);
      if (rand_stall) data_stall = 1'($urandom_range(0, 1));
    end
    req = 1'b0;
    wr  = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL issue_timeout: addr_ok stayed 0 for addr %h, required a handshake", a);
    end
  endtask

  task automatic drain();
    int k;
    data_stall = 1'b0;
    k = 0;
    while (outstanding !== 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (outstanding !== 0) begin
      n_err++;
      $display("FAIL drain_timeout: outstanding=%0d, required 0", outstanding);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (addr_ok !== 1'b0) begin n_err++; $display("FAIL rst_addr_ok: got %b, required 0", addr_ok); end
    n_cmp++; if (outstanding !== 0) begin n_err++; $display("FAIL rst_outstanding: got %0d, required 0", outstanding); end
    n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL rst_data_ok: got %b, required 0", data_ok); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h, required 0", rdata); end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (addr_ok !== 1'b1) begin n_err++; $display("FAIL idle_addr_ok: got %b, required 1 with req low", addr_ok); end
  endtask

  task automatic test_write_read();
    req = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h1000_0010; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    wr = 1'b0; wstrb = 4'h0;
    @(negedge clk);
    req = 1'b0;
    n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL wr_rd_early: data_ok=%b, required 0", data_ok); end
    @(negedge clk);
    n_cmp++; if (data_ok !== 1'b1) begin n_err++; $display("FAIL wr_rd_first_ok: data_ok=%b, required 1", data_ok); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL wr_rd_first_data: got %h, required 0", rdata); end
    @(negedge clk);
    n_cmp++; if (data_ok !== 1'b1) begin n_err++; $display("FAIL wr_rd_second_ok: data_ok=%b, required 1", data_ok); end
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rd_second_data: got %h, required deadbeef", rdata); end
    @(negedge clk);
    n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL wr_rd_pulse: data_ok=%b, required 0", data_ok); end
    drain();
  endtask

  task automatic test_partial_strobe();
    issue(1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0);
    issue(1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0020, 32'h0, 1'b0);
    drain();
    n_cmp++; if (rdata !== 32'h11BB_33DD) begin n_err++; $display("FAIL partial_strobe: got %h, required 11bb33dd", rdata); end
    issue(1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 4'h0, 32'h0000_0020, 32'h0, 1'b0);
    drain();
    n_cmp++; if (rdata !== 32'h11BB_33DD) begin n_err++; $display("FAIL zero_strobe: got %h, required 11bb33dd", rdata); end
  endtask

  task automatic test_backpressure();
    int r0;
    for (int k = 0; k < 5; k++) issue(1'b1, 4'hF, 32'h40 + 32'(4*k), 32'hB000_0000 + 32'(k), 1'b0);
    drain();
    r0 = n_resp;
    data_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req = 1'b1; wr = 1'b0; addr = 32'h40 + 32'(4*k);
      @(negedge clk);
    end
    addr = 32'h50;
    @(negedge clk);
    n_cmp++; if (outstanding !== OW'(QDEPTH)) begin n_err++; $display("FAIL bp_full: outstanding=%0d, required %0d", outstanding, QDEPTH); end
    n_cmp++; if (addr_ok !== 1'b0) begin n_err++; $display("FAIL bp_addr_ok: got %b, required 0 when full", addr_ok); end
    n_cmp++; if (n_resp != r0) begin n_err++; $display("FAIL bp_stalled: %0d responses, required 0", n_resp - r0); end
    data_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      n_cmp++; if (data_ok !== 1'b1) begin n_err++; $display("FAIL bp_burst_%0d: data_ok=%b, required 1", k, data_ok); end
      if (k == 0) begin
        n_cmp++; if (addr_ok !== 1'b1) begin n_err++; $display("FAIL bp_reopen: addr_ok=%b, required 1", addr_ok); end
      end
      if (k == 1) begin
        n_cmp++; if (outstanding !== 3) begin n_err++; $display("FAIL bp_push_pop: outstanding=%0d, required 3", outstanding); end
      end
    end
    drain();
    n_cmp++; if (n_resp - r0 != 5) begin n_err++; $display("FAIL bp_count: %0d responses, required 5", n_resp - r0); end
  endtask

  task automatic test_addr_stall();
    addr_stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h44;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (outstanding !== 0) begin n_err++; $display("FAIL as_outstanding_%0d: got %0d, required 0", k, outstanding); end
      n_cmp++; if (addr_ok !== 1'b0) begin n_err++; $display("FAIL as_addr_ok_%0d: got %b, required 0", k, addr_ok); end
    end
    addr_stall = 1'b0;
    @(negedge clk);
    req = 1'b0;
    n_cmp++; if (outstanding !== 1) begin n_err++; $display("FAIL as_accept: outstanding=%0d, required 1", outstanding); end
    for (int k = 1; k < int'(LAT); k++) begin
      @(negedge clk);
      n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL as_early_%0d: data_ok=%b, required 0", k, data_ok); end
    end
    @(negedge clk);
    n_cmp++; if (data_ok !== 1'b1) begin n_err++; $display("FAIL as_latency: data_ok=%b, required 1", data_ok); end
    drain();
  endtask

  task automatic test_reset_midflight();
    int stale;
    data_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req = 1'b1; wr = 1'b0; addr = 32'h40 + 32'(4*k);
      @(negedge clk);
    end
    req = 1'b0;
    n_cmp++; if (outstanding !== 3) begin n_err++; $display("FAIL mid_pending: outstanding=%0d, required 3", outstanding); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (outstanding !== 0) begin n_err++; $display("FAIL mid_rst_outstanding: got %0d, required 0", outstanding); end
    n_cmp++; if (data_ok !== 1'b0) begin n_err++; $display("FAIL mid_rst_data_ok: got %b, required 0", data_ok); end
    n_cmp++; if (addr_ok !== 1'b0) begin n_err++; $display("FAIL mid_rst_addr_ok: got %b, required 0", addr_ok); end
    data_stall = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (data_ok) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL mid_stale: %0d data_ok pulses, required 0", stale); end
    n_cmp++; if (outstanding !== 0) begin n_err++; $display("FAIL mid_after: outstanding=%0d, required 0", outstanding); end
  endtask

  task automatic test_ordering();
    int r0;
    r0 = n_resp;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      a = 32'h200 + 32'(4*i);
      issue(1'b1, 4'hF, a, $urandom, 1'b1);
      issue(1'b0, 4'h0, a, 32'h0, 1'b1);
    end
    drain();
    n_cmp++; if (n_resp - r0 != 40) begin n_err++; $display("FAIL order_count: %0d responses, required 40", n_resp - r0); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL order_leftover: %0d unanswered, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_backpressure();
    test_addr_stall();
    test_reset_midflight();
    test_ordering();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
